// File: rtl/estacao_reserva_add.sv
// Reservation station for the ADD/SUB unit: captures operands, snoops the CDB for pending tags,
// executes with a fixed latency and holds the result until granted. Optional: ESTACAO_RESERVA_ERRO_EN.
module estacao_reserva_add #(
    parameter logic [2:0] TAG          = 3'd1,
    parameter int         EXEC_LATENCY = 2
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Enable_VQ,
    input  logic [2:0]  Ufop,
    input  logic [15:0] Vj,
    input  logic [15:0] Vk,
    input  logic [2:0]  Qj,
    input  logic [2:0]  Qk,
    input  logic [3:0]  R_target,
    input  logic        CDB_Valid,
    input  logic [2:0]  CDB_Tag,
    input  logic [15:0] CDB_Data,
    input  logic        CDB_Grant,
    output logic        Busy,
    output logic        Result_Valid,
    output logic [2:0]  Result_Tag,
    output logic [15:0] Result_Data,
    output logic [3:0]  Result_Target,
    output logic [1:0]  Estado_dbg
`ifdef ESTACAO_RESERVA_ERRO_EN
    ,
    output logic        Erro_Despacho
`endif
);

    // Handshakes: dispatch is accepted only on an edge where Enable_VQ=1 and Busy=0.
    // Result_Valid and its payload hold steady until an edge samples CDB_Grant=1 in WRITEBACK.

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_OPS  = 2'd1,
        EXEC      = 2'd2,
        WRITEBACK = 2'd3
    } state_t;

    localparam logic [2:0]  OP_SUB     = 3'b010;
    localparam logic [3:0]  CNT_LOAD   = 4'(EXEC_LATENCY - 1);
    localparam logic [15:0] OPER_RESET = 16'hFFF0;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] vj_q, vj_d;
    logic [15:0] vk_q, vk_d;
    logic [2:0]  qj_q, qj_d;
    logic [2:0]  qk_q, qk_d;
    logic [2:0]  ufop_q, ufop_d;
    logic [3:0]  rtgt_q, rtgt_d;
    logic        res_valid_q, res_valid_d;
    logic [15:0] res_data_q, res_data_d;
    logic [3:0]  res_tgt_q, res_tgt_d;

    logic        cap_hit_j, cap_hit_k;
    logic        wait_hit_j, wait_hit_k;
    logic [2:0]  cap_qj, cap_qk;
    logic [15:0] alu_res;

    // A tag of zero means "value present", so only nonzero tags can match the bus.
    assign cap_hit_j  = CDB_Valid && (Qj != 3'd0) && (CDB_Tag == Qj);
    assign cap_hit_k  = CDB_Valid && (Qk != 3'd0) && (CDB_Tag == Qk);
    assign wait_hit_j = CDB_Valid && (qj_q != 3'd0) && (CDB_Tag == qj_q);
    assign wait_hit_k = CDB_Valid && (qk_q != 3'd0) && (CDB_Tag == qk_q);

    assign cap_qj = cap_hit_j ? 3'd0 : Qj;
    assign cap_qk = cap_hit_k ? 3'd0 : Qk;

    // Every opcode other than SUB executes as ADD.
    assign alu_res = (ufop_q == OP_SUB) ? (vj_q - vk_q) : (vj_q + vk_q);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        vj_d        = vj_q;
        vk_d        = vk_q;
        qj_d        = qj_q;
        qk_d        = qk_q;
        ufop_d      = ufop_q;
        rtgt_d      = rtgt_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_tgt_d   = res_tgt_q;

        case (state_q)
            IDLE: begin
                if (Enable_VQ) begin
                    ufop_d = Ufop;
                    rtgt_d = R_target;
                    vj_d   = cap_hit_j ? CDB_Data : Vj;
                    vk_d   = cap_hit_k ? CDB_Data : Vk;
                    qj_d   = cap_qj;
                    qk_d   = cap_qk;
                    if ((cap_qj == 3'd0) && (cap_qk == 3'd0)) begin
                        state_d = EXEC;
                        cnt_d   = CNT_LOAD;
                    end else begin
                        state_d = WAIT_OPS;
                    end
                end
            end

            WAIT_OPS: begin
                // Leave only once the stored tags are already clear, one edge after the last capture.
                if ((qj_q == 3'd0) && (qk_q == 3'd0)) begin
                    state_d = EXEC;
                    cnt_d   = CNT_LOAD;
                end else begin
                    if (wait_hit_j) begin
                        vj_d = CDB_Data;
                        qj_d = 3'd0;
                    end
                    if (wait_hit_k) begin
                        vk_d = CDB_Data;
                        qk_d = 3'd0;
                    end
                end
            end

            EXEC: begin
                if (cnt_q == 4'd0) begin
                    state_d     = WRITEBACK;
                    res_valid_d = 1'b1;
                    res_data_d  = alu_res;
                    res_tgt_d   = rtgt_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            WRITEBACK: begin
                if (CDB_Grant) begin
                    state_d     = IDLE;
                    res_valid_d = 1'b0;
                end
            end

            default: begin
                state_d     = IDLE;
                res_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            vj_q        <= OPER_RESET;
            vk_q        <= OPER_RESET;
            qj_q        <= 3'd0;
            qk_q        <= 3'd0;
            ufop_q      <= 3'd0;
            rtgt_q      <= 4'd0;
            res_valid_q <= 1'b0;
            res_data_q  <= 16'h0000;
            res_tgt_q   <= 4'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            vj_q        <= vj_d;
            vk_q        <= vk_d;
            qj_q        <= qj_d;
            qk_q        <= qk_d;
            ufop_q      <= ufop_d;
            rtgt_q      <= rtgt_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_tgt_q   <= res_tgt_d;
        end
    end

`ifdef ESTACAO_RESERVA_ERRO_EN
    logic erro_q, erro_d;

    // Sticky flag for a dispatch attempted while the station was occupied.
    always_comb begin
        erro_d = erro_q;
        if (Enable_VQ && (state_q != IDLE)) begin
            erro_d = 1'b1;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            erro_q <= 1'b0;
        end else begin
            erro_q <= erro_d;
        end
    end

    assign Erro_Despacho = erro_q;
`endif

    assign Busy          = (state_q != IDLE);
    assign Result_Valid  = res_valid_q;
    assign Result_Tag    = TAG;
    assign Result_Data   = res_data_q;
    assign Result_Target = res_tgt_q;
    assign Estado_dbg    = state_q;

endmodule

// File: tb/tb_estacao_reserva_add.sv
// Self-checking bench for estacao_reserva_add: vector table of ready-operand dispatches plus
// directed sequences for CDB snooping, held grant, busy dispatch and asynchronous reset.
module tb_estacao_reserva_add;

    localparam int LAT = 2;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Enable_VQ;
    logic [2:0]  Ufop;
    logic [15:0] Vj, Vk;
    logic [2:0]  Qj, Qk;
    logic [3:0]  R_target;
    logic        CDB_Valid;
    logic [2:0]  CDB_Tag;
    logic [15:0] CDB_Data;
    logic        CDB_Grant;
    logic        Busy;
    logic        Result_Valid;
    logic [2:0]  Result_Tag;
    logic [15:0] Result_Data;
    logic [3:0]  Result_Target;
    logic [1:0]  Estado_dbg;
`ifdef ESTACAO_RESERVA_ERRO_EN
    logic        Erro_Despacho;
`endif

    int checks   = 0;
    int failures = 0;
    logic [15:0] exp_q[$];

    estacao_reserva_add #(.TAG(3'd1), .EXEC_LATENCY(LAT)) dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .Enable_VQ     (Enable_VQ),
        .Ufop          (Ufop),
        .Vj            (Vj),
        .Vk            (Vk),
        .Qj            (Qj),
        .Qk            (Qk),
        .R_target      (R_target),
        .CDB_Valid     (CDB_Valid),
        .CDB_Tag       (CDB_Tag),
        .CDB_Data      (CDB_Data),
        .CDB_Grant     (CDB_Grant),
        .Busy          (Busy),
        .Result_Valid  (Result_Valid),
        .Result_Tag    (Result_Tag),
        .Result_Data   (Result_Data),
        .Result_Target (Result_Target),
        .Estado_dbg    (Estado_dbg)
`ifdef ESTACAO_RESERVA_ERRO_EN
        ,
        .Erro_Despacho (Erro_Despacho)
`endif
    );

    // Clock / watchdog
    always #5 Clock = ~Clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  rt;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic dispatch(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                            input logic [2:0] qa, input logic [2:0] qb, input logic [3:0] rt);
        Ufop      = op;
        Vj        = a;
        Vk        = b;
        Qj        = qa;
        Qk        = qb;
        R_target  = rt;
        Enable_VQ = 1'b1;
        tick();
        Enable_VQ = 1'b0;
    endtask

    task automatic cdb_pulse(input logic [2:0] tag, input logic [15:0] data);
        CDB_Valid = 1'b1;
        CDB_Tag   = tag;
        CDB_Data  = data;
        tick();
        CDB_Valid = 1'b0;
    endtask

    task automatic wait_result(output int cycles);
        cycles = 0;
        while (Result_Valid !== 1'b1 && cycles < 40) begin
            tick();
            cycles++;
        end
    endtask

    task automatic check_result(input string name, input int cycles, input int exp_cycles,
                                input logic [3:0] rt);
        logic [15:0] exp;
        check({name, "_latency"}, cycles, exp_cycles);
        check({name, "_valid"}, Result_Valid, 1);
        check({name, "_sb_depth"}, exp_q.size(), 1);
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            check({name, "_data"}, Result_Data, exp);
        end
        check({name, "_target"}, Result_Target, rt);
        check({name, "_tag"}, Result_Tag, 1);
        check({name, "_busy"}, Busy, 1);
    endtask

    task automatic grant_once(input string name);
        CDB_Grant = 1'b1;
        tick();
        CDB_Grant = 1'b0;
        check({name, "_rel_busy"}, Busy, 0);
        check({name, "_rel_valid"}, Result_Valid, 0);
    endtask

    task automatic expect_quiet(input string name, input int n);
        int seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (Result_Valid === 1'b1) seen++;
        end
        check({name, "_no_valid"}, seen, 0);
        check({name, "_idle"}, Busy, 0);
    endtask

    initial begin
        int cyc;

        vecs[0] = '{3'b001, 16'd5,     16'd7,     4'd3,  16'd12};
        vecs[1] = '{3'b010, 16'd3,     16'd5,     4'd4,  16'hFFFE};
        vecs[2] = '{3'b111, 16'd100,   16'd200,   4'd9,  16'd300};
        vecs[3] = '{3'b001, 16'hFFFF,  16'd2,     4'd15, 16'd1};
        vecs[4] = '{3'b010, 16'h8000,  16'd1,     4'd0,  16'h7FFF};
        vecs[5] = '{3'b000, 16'h1234,  16'h0111,  4'd7,  16'h1345};

        // Reset
        Reset = 1'b0; Enable_VQ = 1'b0; Ufop = 3'd0; Vj = 16'd0; Vk = 16'd0;
        Qj = 3'd0; Qk = 3'd0; R_target = 4'd0; CDB_Valid = 1'b0; CDB_Tag = 3'd0;
        CDB_Data = 16'd0; CDB_Grant = 1'b0;
        tick(); tick();
        check("rst_busy", Busy, 0);
        check("rst_valid", Result_Valid, 0);
        check("rst_data", Result_Data, 16'h0000);
        check("rst_target", Result_Target, 0);
        check("rst_tag", Result_Tag, 1);
        check("rst_state", Estado_dbg, 0);
`ifdef ESTACAO_RESERVA_ERRO_EN
        check("rst_erro", Erro_Despacho, 0);
`endif
        Reset = 1'b1;
        tick();

        // Ready-operand vectors, grant held high, back-to-back dispatch
        CDB_Grant = 1'b1;
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(vecs[i].exp);
            dispatch(vecs[i].op, vecs[i].a, vecs[i].b, 3'd0, 3'd0, vecs[i].rt);
            check($sformatf("vec%0d_exec_state", i), Estado_dbg, 2);
            wait_result(cyc);
            check_result($sformatf("vec%0d", i), cyc, LAT, vecs[i].rt);
            tick();
            check($sformatf("vec%0d_rel_busy", i), Busy, 0);
            check($sformatf("vec%0d_rel_valid", i), Result_Valid, 0);
        end
        CDB_Grant = 1'b0;

        // Both operands wait on tag 2; unrelated tag 3 must be ignored
        exp_q.push_back(16'd18);
        dispatch(3'b001, 16'h1234, 16'h4321, 3'd2, 3'd2, 4'd6);
        check("wait_state", Estado_dbg, 1);
        tick();
        cdb_pulse(3'd3, 16'd77);
        tick();
        check("wait_still", Estado_dbg, 1);
        cdb_pulse(3'd2, 16'd9);
        wait_result(cyc);
        check_result("wait_same_tag", cyc, 1 + LAT, 4'd6);
        grant_once("wait_same_tag");

        // Operands resolved on different edges: 20 - 4
        exp_q.push_back(16'd16);
        dispatch(3'b010, 16'd0, 16'd0, 3'd2, 3'd3, 4'd2);
        cdb_pulse(3'd3, 16'd4);
        cdb_pulse(3'd2, 16'd20);
        wait_result(cyc);
        check_result("wait_split", cyc, 1 + LAT, 4'd2);
        grant_once("wait_split");

        // Operand forwarded from the CDB on the dispatch edge itself
        exp_q.push_back(16'd5);
        CDB_Valid = 1'b1; CDB_Tag = 3'd2; CDB_Data = 16'd4;
        dispatch(3'b001, 16'hDEAD, 16'd1, 3'd2, 3'd0, 4'd8);
        CDB_Valid = 1'b0;
        check("fwd_state", Estado_dbg, 2);
        wait_result(cyc);
        check_result("fwd", cyc, LAT, 4'd8);
        grant_once("fwd");

        // Grant withheld 5 cycles, second dispatch attempted meanwhile
        exp_q.push_back(16'd30);
        dispatch(3'b001, 16'd10, 16'd20, 3'd0, 3'd0, 4'd5);
        wait_result(cyc);
        check_result("hold", cyc, LAT, 4'd5);
        for (int k = 0; k < 5; k++) begin
            if (k == 1) begin
                Ufop = 3'b010; Vj = 16'd999; Vk = 16'd1; Qj = 3'd0; Qk = 3'd0;
                R_target = 4'd11; Enable_VQ = 1'b1;
            end
            tick();
            Enable_VQ = 1'b0;
            check($sformatf("hold%0d_valid", k), Result_Valid, 1);
            check($sformatf("hold%0d_data", k), Result_Data, 16'd30);
            check($sformatf("hold%0d_target", k), Result_Target, 5);
        end
`ifdef ESTACAO_RESERVA_ERRO_EN
        check("hold_erro", Erro_Despacho, 1);
`endif
        grant_once("hold");
        expect_quiet("hold_ignored", 6);

        // Asynchronous reset during EXEC
        dispatch(3'b001, 16'd1, 16'd2, 3'd0, 3'd0, 4'd3);
        check("rexec_state", Estado_dbg, 2);
        Reset = 1'b0;
        #1;
        check("rexec_busy", Busy, 0);
        check("rexec_valid", Result_Valid, 0);
        check("rexec_data", Result_Data, 16'h0000);
        check("rexec_target", Result_Target, 0);
        check("rexec_state0", Estado_dbg, 0);
`ifdef ESTACAO_RESERVA_ERRO_EN
        check("rexec_erro", Erro_Despacho, 0);
`endif
        tick(); tick();
        Reset = 1'b1;
        CDB_Grant = 1'b1;
        expect_quiet("rexec_after", 10);
        CDB_Grant = 1'b0;

        // Asynchronous reset during WRITEBACK
        dispatch(3'b001, 16'd40, 16'd2, 3'd0, 3'd0, 4'd12);
        wait_result(cyc);
        check("rwb_valid_before", Result_Valid, 1);
        Reset = 1'b0;
        #1;
        check("rwb_valid", Result_Valid, 0);
        check("rwb_data", Result_Data, 16'h0000);
        check("rwb_busy", Busy, 0);
        tick();
        Reset = 1'b1;
        expect_quiet("rwb_after", 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/estacao_reserva_add.md
ESTACAO_RESERVA_ADD -- requirements
Module: estacao_reserva_add

Interface
REQ-001 Parameter TAG, default 3'd1, SHALL be the station identifier broadcast on the CDB (ADD1=1, ADD2=2).
REQ-002 Parameter EXEC_LATENCY, default 2, SHALL be the execute cycles (legal range 1..15).
REQ-003 Clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset.
REQ-005 Enable_VQ  input  1  dispatch strobe; load operands this edge.
REQ-006 Ufop  input  3  opcode: 3'b001 ADD, 3'b010 SUB, any other value executes as ADD.
REQ-007 Vj, Vk  input  16 each  operand values, valid when matching Q is 0.
REQ-008 Qj, Qk  input  3 each  producing-station tags; 0 means operand ready.
REQ-009 R_target  input  4  destination register, carried through to the result.
REQ-010 CDB_Valid, CDB_Tag[2:0], CDB_Data[15:0]  input  result bus snooped for operands.
REQ-011 CDB_Grant  input  1  arbiter accepts this station's broadcast.
REQ-012 Busy  output  1  station occupied; the dispatch unit issues only when low.
REQ-013 Result_Valid  output  1  result requesting the CDB.
REQ-014 Result_Tag, Result_Data[15:0], Result_Target[3:0]  output  broadcast payload; Result_Tag is constantly TAG.

Function
REQ-015 The FSM SHALL have four states: IDLE, WAIT_OPS, EXEC, WRITEBACK; Busy SHALL be 1 in every state except IDLE.
REQ-016 In IDLE with Enable_VQ=1 the block SHALL capture Ufop, R_target, Vj/Qj and Vk/Qk.
REQ-017 At capture, if CDB_Valid=1 and CDB_Tag equals a nonzero incoming Qx, the block SHALL load CDB_Data into that operand and clear that Qx to 0.
REQ-018 After capture the FSM SHALL go to EXEC when both effective Q are 0, else to WAIT_OPS.
REQ-019 In WAIT_OPS, each edge with CDB_Valid=1 and CDB_Tag equal to a stored nonzero Qx SHALL load CDB_Data and clear that Qx; both operands may resolve on the same edge.
REQ-020 WAIT_OPS SHALL go to EXEC on the edge after both stored Q reach 0.
REQ-021 Entry to EXEC SHALL load a 4-bit counter with EXEC_LATENCY-1; EXEC SHALL decrement it each edge and go to WRITEBACK at the edge where it reads 0.
REQ-022 On entry to WRITEBACK the block SHALL register Result_Data = Vj+Vk (ADD) or Vj-Vk (SUB), modulo 2^16, and set Result_Target = stored R_target.
REQ-023 With ready operands, Result_Valid SHALL rise exactly EXEC_LATENCY edges after the dispatch edge.
REQ-024 Result_Valid, Result_Data and Result_Target SHALL stay stable in WRITEBACK until sampled with CDB_Grant=1; that edge SHALL return the FSM to IDLE and clear Result_Valid and Busy.
REQ-025 Enable_VQ while Busy=1 SHALL be ignored, leaving all state unchanged.
REQ-026 Enable_VQ in the cycle after a grant (Busy=0) SHALL be accepted normally; zero bubble cycles are required.
REQ-027 CDB_Grant outside WRITEBACK SHALL be ignored.

Reset
REQ-028 Reset low SHALL immediately force IDLE, Busy=0, Result_Valid=0, Result_Data=16'h0000, Result_Target=0, counter=0, stored Vj=Vk=16'hFFF0, Qj=Qk=0, regardless of state.
REQ-029 Reset asserted mid-EXEC or mid-WRITEBACK SHALL discard the operation with no broadcast after release.

Configuration
REQ-030 With ESTACAO_RESERVA_ERRO_EN defined, an extra output Erro_Despacho (1 bit) SHALL set sticky on any Enable_VQ=1 while Busy=1 and clear only on Reset.
REQ-031 Without ESTACAO_RESERVA_ERRO_EN, the port and its logic SHALL be absent and behaviour is otherwise identical.

Verification
REQ-032 Reset, dispatch ADD Vj=5, Vk=7, Qj=Qk=0, latency 2, grant held 1 -> Result_Valid 2 edges later, Data=12, Tag=1, Busy low the next cycle.
REQ-033 Dispatch SUB Vj=3, Vk=5 -> Result_Data=16'hFFFE (wrap-around).
REQ-034 Dispatch Qj=2, Qk=2; CDB tag 2 data 9 four cycles later -> both operands 9, ADD result 18, Valid at broadcast edge+1+EXEC_LATENCY.
REQ-035 Dispatch Qj=2 with CDB tag 2 data 4 on the same edge, Vk=1 -> no WAIT_OPS, result 5 at the nominal latency.
REQ-036 Hold grant low 5 cycles in WRITEBACK, second Enable_VQ during that time -> payload stable, second dispatch ignored, Erro_Despacho=1 when the macro is enabled.
REQ-037 Assert Reset in EXEC -> all outputs at reset values immediately; no Result_Valid after release.
